// File: rtl/mem_responder.sv
// Word-RAM responder for the MAR/MDR interface: one access per strobe, with wait states.
// Define MEM_INIT_EN to preload the RAM with the built-in image; otherwise it starts zeroed.
module mem_responder #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone, StHold} state_e;

  localparam logic [3:0]      WaitInit = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic              both_q, both_d;
  logic [DATA_W-1:0] mdat_q, mdat_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              in_range;
  logic              access;
  logic              mem_we;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef MEM_INIT_EN
  localparam int unsigned InitLen = 1;
  localparam logic [31:0] InitImage [InitLen] = '{32'h0880_0055};

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    for (int i = 0; i < int'(InitLen) && i < int'(DEPTH); i++) mem[i] = DATA_W'(InitImage[i]);
  end
`else
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
  end
`endif

  assign in_range = ({1'b0, addr_q} < DepthLim);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mdat_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mdat_q  <= mdat_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    wr_q   <= wr_d;
    both_q <= both_d;
  end

  // RAM is never cleared; clr only suppresses an in-flight commit.
  always_ff @(posedge clk) begin
    if (mem_we && !clr) mem[addr_q] <= data_q;
  end

  // Requests always pass through BUSY; the counter holds the remaining wait cycles,
  // so completion lands WAIT_CYCLES+1 edges after the sampling edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    both_d  = both_q;
    mdat_d  = mdat_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Read || Write) begin
          addr_d  = addr;
          data_d  = data_in;
          wr_d    = Write;
          both_d  = Read && Write;
          cnt_d   = WaitInit;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: state_d = (Read || Write) ? StHold : StIdle;
      StHold: if (!Read && !Write) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (access) begin
      ready_d = 1'b1;
      err_d   = both_q || !in_range;
      if (!both_q && !wr_q) mdat_d = in_range ? mem[addr_q] : '0;
    end
    mem_we = access && wr_q && !both_q && in_range;
  end

  always_comb begin
    busy      = (state_q != StIdle);
    Mdatain   = mdat_q;
    mem_ready = ready_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: wait states, held strobes, faults and mid-access clear.
module tb_mem_responder;

  localparam int unsigned W = 3;
  localparam int unsigned D = 256;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        Read = 1'b0;
  logic        Write = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] Mdatain;
  logic        mem_ready;
  logic        busy;
  logic        err;

  mem_responder #(
    .ADDR_W(9),
    .DATA_W(32),
    .DEPTH(D),
    .WAIT_CYCLES(W)
  ) u_dut (
    .clk(clk),
    .clr(clr),
    .Read(Read),
    .Write(Write),
    .addr(addr),
    .data_in(data_in),
    .Mdatain(Mdatain),
    .mem_ready(mem_ready),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model_mem [512];
  logic [31:0] mdat_m;
  int          n_total = 0;
  int          n_bad = 0;
  int          ready_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: updated when a request is driven, result queued for the monitor.
  task automatic push_exp(input logic rd, input logic wr, input logic [8:0] a,
                          input logic [31:0] d);
    exp_t e;
    if (rd && wr) begin
      e.err = 1'b1;
    end else if (int'(a) >= int'(D)) begin
      e.err = 1'b1;
      if (rd) mdat_m = '0;
    end else begin
      e.err = 1'b0;
      if (wr) model_mem[a] = d;
      else mdat_m = model_mem[a];
    end
    e.data = mdat_m;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      ready_cnt++;
      if (sb.size() == 0) begin
        check_eq("spurious_ready", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("rdata", Mdatain, mon_e.data);
        check_eq("err", {31'd0, err}, {31'd0, mon_e.err});
      end
    end
  end

  // One strobed access; inputs are scrambled after sampling to prove they were latched.
  task automatic access(input logic rd, input logic wr, input logic [8:0] a,
                        input logic [31:0] d);
    int edges;
    bit seen;
    @(negedge clk);
    Read = rd; Write = wr; addr = a; data_in = d;
    push_exp(rd, wr, a, d);
    @(posedge clk); #1;
    Read = 1'b0; Write = 1'b0; addr = ~a; data_in = ~d;
    edges = 0;
    seen = 1'b0;
    while (!seen && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (mem_ready === 1'b1) seen = 1'b1;
    end
    check_eq("latency", 32'(edges), 32'(W + 1));
    @(posedge clk); #1;
    check_eq("idle_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < 512; i++) model_mem[i] = '0;
`ifdef MEM_INIT_EN
    model_mem[0] = 32'h0880_0055;
`endif
    mdat_m = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mdat", Mdatain, 32'd0);
    check_eq("rst_ready", {31'd0, mem_ready}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    clr = 1'b0;

    access(1'b1, 1'b0, 9'h000, 32'h0);
    access(1'b0, 1'b1, 9'h05F, 32'h0000_1234);
    access(1'b1, 1'b0, 9'h05F, 32'h0);
    access(1'b0, 1'b1, 9'h010, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 9'h010, 32'h0);

    // Both strobes: fault, RAM and Mdatain untouched.
    access(1'b0, 1'b1, 9'h020, 32'h0000_0011);
    access(1'b1, 1'b1, 9'h020, 32'hFFFF_FFFF);
    access(1'b1, 1'b0, 9'h020, 32'h0);

    // Out of range: write discarded (no aliasing into 0xFF), read returns zero.
    access(1'b0, 1'b1, 9'h0FF, 32'h0000_A5A5);
    access(1'b0, 1'b1, 9'h1FF, 32'h0000_0077);
    access(1'b1, 1'b0, 9'h0FF, 32'h0);
    access(1'b1, 1'b0, 9'h1FF, 32'h0);

    // Held Read gives one pulse; a one-cycle drop then reassert gives a second.
    base = ready_cnt;
    @(negedge clk);
    Read = 1'b1; addr = 9'h010;
    push_exp(1'b1, 1'b0, 9'h010, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    check_eq("hold_one_pulse", 32'(ready_cnt - base), 32'd1);
    Read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    Read = 1'b1;
    push_exp(1'b1, 1'b0, 9'h010, 32'h0);
    @(posedge clk); #1;
    Read = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); #1;
    check_eq("hold_two_pulses", 32'(ready_cnt - base), 32'd2);

    // clr during the second BUSY cycle aborts a write.
    access(1'b0, 1'b1, 9'h030, 32'h0000_5555);
    access(1'b1, 1'b0, 9'h05F, 32'h0);
    base = ready_cnt;
    @(negedge clk);
    Write = 1'b1; addr = 9'h030; data_in = 32'h0000_CAFE;
    @(posedge clk); #1;
    Write = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    mdat_m = '0;
    check_eq("clr_busy", {31'd0, busy}, 32'd0);
    check_eq("clr_mdat", Mdatain, 32'd0);
    check_eq("clr_ready", {31'd0, mem_ready}, 32'd0);
    repeat (8) @(posedge clk);
    @(negedge clk); #1;
    check_eq("clr_no_pulse", 32'(ready_cnt - base), 32'd0);
    access(1'b1, 1'b0, 9'h030, 32'h0);
    check_eq("final_mdat", Mdatain, 32'h0000_5555);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
